aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Round sequencer for the AES encryption datapath. It accepts one block request at a time through a valid/ready handshake, triggers key expansion when the key changes, and drives per-round control strobes and the round-key index into the state-matrix datapath. It then presents completion through an output valid/ready handshake. It sits between the host-side request interface and the AddRoundKey / SubBytes / ShiftRows / MixColumns datapath plus the key-expansion unit.

## Interface
- NR, 14, number of rounds; legal values 10, 12, 14 (AES-128/192/256)
- CYC_PER_ROUND, 1, datapath cycles per round; ≥1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- key_load  in  1  pulse: new key presented; invalidates round-key schedule
- ke_start  out  1  one-cycle pulse starting key expansion
- ke_done  in  1  pulse: all NR+1 round keys available
- in_valid  in  1  block request
- in_ready  out  1  request accepted when in_valid && in_ready
- in_dec  in  1  request direction (1 = decrypt), sampled at accept
- dp_load  out  1  load state ← word ^ round key rk_idx
- dp_round  out  1  round datapath active
- dp_commit  out  1  last sub-cycle of a round; datapath registers round result
- dp_final  out  1  final round (MixColumns bypassed)
- dp_dec  out  1  inverse transforms selected
- rk_idx  out  4  round-key index, 0..NR
- out_valid  out  1  result in datapath valid
- out_ready  in  1  consumer accepts result
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, KEXP, LOAD, ROUND, FINAL, HOLD.
- key_valid flag:
  - 0 at reset and on key_load.
  - 1 on ke_done while in KEXP. ke_done in any other state is ignored.
- IDLE:
  - in_ready = key_valid.
  - key_load → KEXP; ke_start pulses on the first KEXP cycle.
  - Accepted request → LOAD; dec latched.
  - key_load and in_valid in the same cycle: key_load wins and in_ready = 0.
- KEXP: waits for ke_done → IDLE. A key_load in KEXP re-pulses ke_start on the next cycle.
- key_load in LOAD/ROUND/FINAL/HOLD is latched as key_pend. The current block completes with the old schedule. Exit from HOLD goes to KEXP instead of IDLE.
- LOAD: 1 cycle.
  - dp_load = 1.
  - rk_idx = dec ? NR : 0.
  - Round counter r = 1, sub-cycle counter s = 0.
- ROUND: rounds r = 1..NR-1.
  - dp_round = 1 every cycle.
  - rk_idx = dec ? NR-r : r.
  - dp_commit = 1 when s = CYC_PER_ROUND-1; then s wraps to 0 and r increments.
  - After the commit of r = NR-1 → FINAL.
- FINAL: CYC_PER_ROUND cycles.
  - dp_round = dp_final = 1.
  - rk_idx = dec ? 0 : NR.
  - dp_commit on the last sub-cycle → HOLD.
- HOLD:
  - out_valid = 1 until out_ready.
  - The state is frozen; rk_idx holds its last value.
  - Handshake → IDLE (or KEXP if key_pend).
- dp_dec = latched dec in LOAD..HOLD, else 0.
- Counters: r is 4 bits and s is ceil(log2(CYC_PER_ROUND+1)) bits. No wrap beyond NR is possible.

## Timing
- Reset values: all outputs 0, state IDLE, key_valid = 0, key_pend = 0, r = s = 0.
- Reset mid-operation abandons the block. The next cycle after reset deassertion is IDLE with outputs 0.
- Accept at cycle 0:
  - LOAD at cycle 1.
  - Rounds at cycles 2..1+NR·CYC_PER_ROUND.
  - out_valid first high at cycle 2+NR·CYC_PER_ROUND (16 for defaults).
- With out_ready held high, out_valid lasts 1 cycle, IDLE follows, and the next accept is possible on that IDLE cycle. Minimum initiation interval is NR·CYC_PER_ROUND+3 cycles.
- ke_start: exactly one cycle per KEXP entry or restart.
- All outputs are registered state decodes; there are no combinational paths from inputs to outputs except in_ready ← key_load in IDLE.

## Configuration
- AES_DEC_EN:
  - Defined: in_dec is honoured; rk_idx runs NR→0 and dp_dec follows the latched direction.
  - Undefined: in_dec is ignored, dec is constant 0, dp_dec is tied 0 and rk_idx always ascends.

## Structure
- aes_pkg holds:
  - the state enum;
  - NR constants AES128_NR = 10, AES192_NR = 12, AES256_NR = 14;
  - RK_IDX_W = 4.
- One sub-module, aes_round_cnt: round and sub-cycle counter with the commit/last-round flags. The FSM stays in aes_round_ctrl.

## Test plan
- Reset, then key_load pulse → ke_start high exactly 1 cycle later. in_ready stays 0 until ke_done, then 1 on the next cycle.
- Defaults, encrypt request accepted at cycle 0, out_ready = 1:
  - dp_load at cycle 1.
  - rk_idx 1..13 over cycles 2..14.
  - dp_final with rk_idx = 14 at cycle 15.
  - out_valid at cycle 16.
- CYC_PER_ROUND = 3, NR = 10:
  - dp_commit every 3rd cycle, 10 commits.
  - out_valid at cycle 32.
  - out_ready held 0 for 5 cycles → out_valid held and rk_idx stable.
- AES_DEC_EN with in_dec = 1 → rk_idx sequence 14, 13, ..., 0 and dp_dec = 1 throughout. Without the macro → ascending sequence and dp_dec = 0.
- key_load during ROUND → block completes and out_valid rises on schedule. After the HOLD handshake the FSM enters KEXP, ke_start pulses, and in_ready = 0 until ke_done.
- rst asserted during ROUND → next cycle all outputs 0, key_valid = 0, and in_ready = 0 until a new key is expanded.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEXP,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL,
        ST_HOLD
    } state_t;

    localparam int AES128_NR = 10;
    localparam int AES192_NR = 12;
    localparam int AES256_NR = 14;

    localparam int RK_IDX_W = 4;

endpackage

// File: rtl/aes_round_cnt.sv
// Round / sub-cycle counter: init loads round 1, adv steps through sub-cycles and rounds.
module aes_round_cnt
    import aes_pkg::*;
#(
    parameter int NR            = AES256_NR,
    parameter int CYC_PER_ROUND = 1,
    localparam int S_W          = $clog2(CYC_PER_ROUND + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    input  logic                adv,
    output logic [RK_IDX_W-1:0] r,
    output logic                commit,
    output logic                last_round
);

    logic [S_W-1:0] s;

    assign commit     = (s == S_W'(CYC_PER_ROUND - 1));
    assign last_round = (r == RK_IDX_W'(NR - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
            s <= '0;
        end else if (init) begin
            r <= RK_IDX_W'(1);
            s <= '0;
        end else if (adv) begin
            if (commit) begin
                s <= '0;
                if (r != RK_IDX_W'(NR)) r <= r + 1'b1;
            end else begin
                s <= s + 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: request handshake, key-expansion trigger, per-round strobes.
// Optional decryption direction is enabled by defining AES_DEC_EN.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR            = AES256_NR,
    parameter int CYC_PER_ROUND = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_load,
    output logic                ke_start,
    input  logic                ke_done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_dec,
    output logic                dp_load,
    output logic                dp_round,
    output logic                dp_commit,
    output logic                dp_final,
    output logic                dp_dec,
    output logic [RK_IDX_W-1:0] rk_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam logic [RK_IDX_W-1:0] NR_IDX = RK_IDX_W'(NR);

    state_t              state, state_next;
    logic                key_valid, key_pend, ke_start_q, dec, accept;
    logic [RK_IDX_W-1:0] r;
    logic                commit, last_round;

    aes_round_cnt #(.NR(NR), .CYC_PER_ROUND(CYC_PER_ROUND)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .init       (state == ST_LOAD),
        .adv        (state == ST_ROUND || state == ST_FINAL),
        .r          (r),
        .commit     (commit),
        .last_round (last_round)
    );

    // A new key in IDLE takes priority over a simultaneous request.
    assign in_ready = (state == ST_IDLE) && key_valid && !key_load;
    assign accept   = in_valid && in_ready;

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (key_load) state_next = ST_KEXP;
                      else if (accept) state_next = ST_LOAD;
            ST_KEXP:  if (!key_load && ke_done) state_next = ST_IDLE;
            ST_LOAD:  state_next = ST_ROUND;
            ST_ROUND: if (commit && last_round) state_next = ST_FINAL;
            ST_FINAL: if (commit) state_next = ST_HOLD;
            ST_HOLD:  if (out_ready) state_next = (key_pend || key_load) ? ST_KEXP : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            key_valid  <= 1'b0;
            key_pend   <= 1'b0;
            ke_start_q <= 1'b0;
        end else begin
            state      <= state_next;
            ke_start_q <= (state_next == ST_KEXP) && (state != ST_KEXP || key_load);
            if (key_load) key_valid <= 1'b0;
            else if (state == ST_KEXP && ke_done) key_valid <= 1'b1;
            if (state_next == ST_KEXP) key_pend <= 1'b0;
            else if (key_load && state inside {ST_LOAD, ST_ROUND, ST_FINAL, ST_HOLD}) key_pend <= 1'b1;
        end
    end

`ifdef AES_DEC_EN
    logic dec_q;
    always_ff @(posedge clk) begin
        if (rst) dec_q <= 1'b0;
        else if (accept) dec_q <= in_dec;
    end
    assign dec = dec_q;
`else
    logic unused_in_dec;
    assign unused_in_dec = in_dec;
    assign dec = 1'b0;
`endif

    always_comb begin
        dp_load   = 1'b0;
        dp_round  = 1'b0;
        dp_commit = 1'b0;
        dp_final  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = '0;
        case (state)
            ST_LOAD: begin
                dp_load = 1'b1;
                rk_idx  = dec ? NR_IDX : '0;
            end
            ST_ROUND: begin
                dp_round  = 1'b1;
                dp_commit = commit;
                rk_idx    = dec ? NR_IDX - r : r;
            end
            ST_FINAL: begin
                dp_round  = 1'b1;
                dp_final  = 1'b1;
                dp_commit = commit;
                rk_idx    = dec ? '0 : NR_IDX;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                rk_idx    = dec ? '0 : NR_IDX;
            end
            default: ;
        endcase
    end

    assign dp_dec   = dec && (state inside {ST_LOAD, ST_ROUND, ST_FINAL, ST_HOLD});
    assign busy     = (state != ST_IDLE);
    assign ke_start = ke_start_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: two configurations (NR=14/C=1 and NR=10/C=3) share stimulus.
module tb_aes_round_ctrl;

`ifdef AES_DEC_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam int NRS [2] = '{14, 10};
    localparam int CS  [2] = '{1, 3};

    logic clk, rst;
    logic key_load, ke_done, in_valid, in_dec, out_ready;
    logic [1:0] ke_start_o, in_ready_o, dp_load_o, dp_round_o, dp_commit_o;
    logic [1:0] dp_final_o, dp_dec_o, out_valid_o, busy_o;
    logic [3:0] rk_o [2];

    int checks = 0;
    int errors = 0;

    aes_round_ctrl #(.NR(14), .CYC_PER_ROUND(1)) dut_a (
        .clk(clk), .rst(rst), .key_load(key_load), .ke_start(ke_start_o[0]),
        .ke_done(ke_done), .in_valid(in_valid), .in_ready(in_ready_o[0]), .in_dec(in_dec),
        .dp_load(dp_load_o[0]), .dp_round(dp_round_o[0]), .dp_commit(dp_commit_o[0]),
        .dp_final(dp_final_o[0]), .dp_dec(dp_dec_o[0]), .rk_idx(rk_o[0]),
        .out_valid(out_valid_o[0]), .out_ready(out_ready), .busy(busy_o[0])
    );

    aes_round_ctrl #(.NR(10), .CYC_PER_ROUND(3)) dut_b (
        .clk(clk), .rst(rst), .key_load(key_load), .ke_start(ke_start_o[1]),
        .ke_done(ke_done), .in_valid(in_valid), .in_ready(in_ready_o[1]), .in_dec(in_dec),
        .dp_load(dp_load_o[1]), .dp_round(dp_round_o[1]), .dp_commit(dp_commit_o[1]),
        .dp_final(dp_final_o[1]), .dp_dec(dp_dec_o[1]), .rk_idx(rk_o[1]),
        .out_valid(out_valid_o[1]), .out_ready(out_ready), .busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] @%0t: got %0d, expected %0d", name, inst, $time, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 key expansion, 2 block in flight.
    // k counts cycles since accept (1 = load cycle).
    int  ph [2], k [2];
    bit  kv [2], kp [2], kst [2], mdec [2];
    bit  armed = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ph[i] = 0; k[i] = 0; kv[i] = 0; kp[i] = 0; kst[i] = 0; mdec[i] = 0;
                armed = 1'b1;
            end else begin
                bit done_blk;
                done_blk = (ph[i] == 2) && (k[i] >= 2 + NRS[i] * CS[i]);
                kst[i] = 1'b0;
                case (ph[i])
                    0: if (key_load) begin
                           ph[i] = 1; kst[i] = 1; kv[i] = 0;
                       end else if (in_valid && kv[i]) begin
                           ph[i] = 2; k[i] = 1; mdec[i] = DEC_EN && in_dec;
                       end
                    1: if (key_load) begin
                           kst[i] = 1; kv[i] = 0;
                       end else if (ke_done) begin
                           kv[i] = 1; ph[i] = 0;
                       end
                    default: begin
                        if (key_load) begin kp[i] = 1; kv[i] = 0; end
                        if (!done_blk) k[i]++;
                        else if (out_ready) begin
                            if (kp[i]) begin ph[i] = 1; kst[i] = 1; kp[i] = 0; end
                            else ph[i] = 0;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                int nr, c, j, rr, e_rk;
                bit e_load, e_round, e_commit, e_final, e_ov, e_dec;
                nr = NRS[i]; c = CS[i];
                e_load = 0; e_round = 0; e_commit = 0; e_final = 0; e_ov = 0; e_rk = 0; e_dec = 0;
                if (ph[i] == 2) begin
                    e_dec = mdec[i];
                    if (k[i] == 1) begin
                        e_load = 1; e_rk = mdec[i] ? nr : 0;
                    end else if (k[i] < 2 + nr * c) begin
                        j = k[i] - 2; rr = j / c + 1;
                        e_round = 1; e_commit = (j % c) == c - 1; e_final = (rr == nr);
                        e_rk = e_final ? (mdec[i] ? 0 : nr) : (mdec[i] ? nr - rr : rr);
                    end else begin
                        e_ov = 1; e_rk = mdec[i] ? 0 : nr;
                    end
                end
                check("busy", i, busy_o[i], ph[i] != 0);
                check("ke_start", i, ke_start_o[i], kst[i]);
                check("in_ready", i, in_ready_o[i], ph[i] == 0 && kv[i] && !key_load);
                check("dp_load", i, dp_load_o[i], e_load);
                check("dp_round", i, dp_round_o[i], e_round);
                check("dp_commit", i, dp_commit_o[i], e_commit);
                check("dp_final", i, dp_final_o[i], e_final);
                check("dp_dec", i, dp_dec_o[i], e_dec);
                check("out_valid", i, out_valid_o[i], e_ov);
                check("rk_idx", i, rk_o[i], e_rk);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_ov [2];
        int commits_b;
        rst = 1; key_load = 0; ke_done = 0; in_valid = 0; in_dec = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("lit_reset_busy", i, busy_o[i], 0);
            check("lit_reset_in_ready", i, in_ready_o[i], 0);
            check("lit_reset_rk", i, rk_o[i], 0);
        end

        // Key expansion: ke_start one cycle after key_load, in_ready after ke_done.
        tick(); key_load = 1; @(negedge clk);
        check("lit_ke_start_same", 0, ke_start_o[0], 0);
        tick(); key_load = 0; @(negedge clk);
        for (int i = 0; i < 2; i++) check("lit_ke_start_next", i, ke_start_o[i], 1);
        tick(); @(negedge clk);
        check("lit_ke_start_once", 0, ke_start_o[0], 0);
        tick(); ke_done = 1; @(negedge clk);
        check("lit_in_ready_kexp", 0, in_ready_o[0], 0);
        tick(); ke_done = 0; @(negedge clk);
        for (int i = 0; i < 2; i++) check("lit_in_ready_after_kd", i, in_ready_o[i], 1);

        // Encrypt block, out_ready held high.
        tick(); in_valid = 1; in_dec = 0; out_ready = 1; @(negedge clk);
        first_ov = '{-1, -1}; commits_b = 0;
        for (int kk = 1; kk <= 40; kk++) begin
            tick(); in_valid = 0; @(negedge clk);
            if (kk == 1) check("lit_dp_load_c1", 0, dp_load_o[0], 1);
            if (kk >= 2 && kk <= 14) check("lit_rk_asc", 0, rk_o[0], kk - 1);
            if (kk == 15) begin
                check("lit_final_c15", 0, dp_final_o[0], 1);
                check("lit_rk_c15", 0, rk_o[0], 14);
            end
            for (int i = 0; i < 2; i++) if (out_valid_o[i] && first_ov[i] < 0) first_ov[i] = kk;
            if (dp_commit_o[1]) commits_b++;
        end
        check("lit_ov_cycle", 0, first_ov[0], 16);
        check("lit_ov_cycle", 1, first_ov[1], 32);
        check("lit_commit_count", 1, commits_b, 10);

        // Decrypt-direction block with out_ready held low past completion.
        tick(); in_valid = 1; in_dec = 1; out_ready = 0; @(negedge clk);
        for (int kk = 1; kk <= 37; kk++) begin
            tick(); in_valid = 0; out_ready = (kk == 37); @(negedge clk);
            if (kk == 1) begin
                check("lit_dec_rk_load", 0, rk_o[0], DEC_EN ? 14 : 0);
                check("lit_dp_dec", 0, dp_dec_o[0], DEC_EN);
            end
            if (kk == 2) check("lit_dec_rk_r1", 0, rk_o[0], DEC_EN ? 13 : 1);
            if (kk == 15) check("lit_dec_rk_final", 0, rk_o[0], DEC_EN ? 0 : 14);
            if (kk >= 32 && kk <= 36) begin
                check("lit_hold_ov", 1, out_valid_o[1], 1);
                check("lit_hold_rk", 1, rk_o[1], DEC_EN ? 0 : 10);
            end
        end
        tick(); @(negedge clk);
        for (int i = 0; i < 2; i++) check("lit_idle_after_hold", i, busy_o[i], 0);

        // key_load during ROUND: block completes, then re-expansion.
        tick(); in_valid = 1; in_dec = 0; out_ready = 1; @(negedge clk);
        for (int kk = 1; kk <= 45; kk++) begin
            tick(); in_valid = 0; key_load = (kk == 5); ke_done = (kk == 40); @(negedge clk);
            if (kk == 16) check("lit_pend_ov", 0, out_valid_o[0], 1);
            if (kk == 17) check("lit_pend_ke_start", 0, ke_start_o[0], 1);
            if (kk == 32) check("lit_pend_ov", 1, out_valid_o[1], 1);
            if (kk == 33) check("lit_pend_ke_start", 1, ke_start_o[1], 1);
            if (kk == 38) check("lit_pend_in_ready", 0, in_ready_o[0], 0);
            if (kk == 41) for (int i = 0; i < 2; i++) check("lit_rekey_in_ready", i, in_ready_o[i], 1);
        end

        // Reset during ROUND abandons the block and the key schedule.
        tick(); in_valid = 1; key_load = 0; ke_done = 0; @(negedge clk);
        for (int kk = 1; kk <= 8; kk++) begin
            tick(); rst = (kk == 5); in_valid = (kk >= 7); @(negedge clk);
            if (kk == 6 || kk == 8) for (int i = 0; i < 2; i++) begin
                check("lit_rst_busy", i, busy_o[i], 0);
                check("lit_rst_round", i, dp_round_o[i], 0);
                check("lit_rst_in_ready", i, in_ready_o[i], 0);
            end
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst       = ($urandom_range(0, 799) == 0);
            key_load  = ($urandom_range(0, 39) == 0);
            ke_done   = ($urandom_range(0, 3) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_dec    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
        end
        tick();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
